// File: rtl/modn_counter.sv
// Parametrised modulo-N up/down counter with synchronous load, enable,
// wrap or one-shot (saturating) mode and a cascadable terminal-count output.
module modn_counter #(
  parameter int unsigned MODULUS   = 6,
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  localparam longint unsigned MODL  = 64'(MODULUS);
  localparam longint unsigned SPAN  = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

  // Reject parameter sets that cannot be represented or are out of range
  if (MODULUS < 2 || MODL > SPAN || RESET_VAL >= MODULUS) begin : gBadParams
    $error("modn_counter: illegal MODULUS/WIDTH/RESET_VAL combination");
  end

  logic [WIDTH-1:0] term;
  logic             atTerm;
  logic             legalLoad;

  logic [WIDTH-1:0] countNext;
  logic             wrapNext;
  logic             doneNext;
  logic             loadErrNext;

  // Terminal value follows direction combinationally; tc feeds the next stage
  always_comb begin
    term      = up ? MAXV : '0;
    atTerm    = (count == term);
    tc        = en & atTerm;
    legalLoad = (64'(load_val) < MODL);
  end

  // Next-state selection: load > count > hold (reset handled in the register)
  always_comb begin
    countNext   = count;
    wrapNext    = 1'b0;
    doneNext    = done;
    loadErrNext = 1'b0;
    if (load) begin
      if (legalLoad) begin
        countNext = load_val;
        doneNext  = 1'b0;
      end else begin
        loadErrNext = 1'b1;
      end
    end else if (en) begin
      if (!atTerm) begin
        countNext = up ? count + WIDTH'(1) : count - WIDTH'(1);
      end else if (!oneshot) begin
        countNext = up ? '0 : MAXV;
        wrapNext  = 1'b1;
      end else begin
        doneNext = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= RSTV;
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= countNext;
      wrap     <= wrapNext;
      done     <= doneNext;
      load_err <= loadErrNext;
    end
  end

  // Count must never leave 0..MODULUS-1
  always_ff @(posedge clk) begin
    if (rst_n) assert (64'(count) < MODL);
  end

endmodule

// File: tb/tb_modn_counter.sv
// Directed scoreboard bench for modn_counter: mod-6, mod-10 and a cascaded pair.
module tb_modn_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Mod-6 instance
  logic       aEn, aUp, aOne, aLoad;
  logic [2:0] aLv, aCount;
  logic       aTc, aWrap, aDone, aErr;

  // Mod-10 instance
  logic       bEn, bUp, bOne, bLoad;
  logic [3:0] bLv, bCount;
  logic       bTc, bWrap, bDone, bErr;

  // Cascade: low stage mod-6, high stage mod-10 enabled by low tc
  logic       cEn;
  logic [2:0] loCount;
  logic [3:0] hiCount;
  logic       loTc, loWrap, loDone, loErr;
  logic       hiTc, hiWrap, hiDone, hiErr;

  modn_counter #(.MODULUS(6), .WIDTH(3), .RESET_VAL(0)) dutA (
    .clk(clk), .rst_n(rst_n), .en(aEn), .up(aUp), .oneshot(aOne), .load(aLoad),
    .load_val(aLv), .count(aCount), .tc(aTc), .wrap(aWrap), .done(aDone), .load_err(aErr));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) dutB (
    .clk(clk), .rst_n(rst_n), .en(bEn), .up(bUp), .oneshot(bOne), .load(bLoad),
    .load_val(bLv), .count(bCount), .tc(bTc), .wrap(bWrap), .done(bDone), .load_err(bErr));

  modn_counter #(.MODULUS(6), .WIDTH(3), .RESET_VAL(0)) dutLo (
    .clk(clk), .rst_n(rst_n), .en(cEn), .up(1'b1), .oneshot(1'b0), .load(1'b0),
    .load_val(3'd0), .count(loCount), .tc(loTc), .wrap(loWrap), .done(loDone), .load_err(loErr));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) dutHi (
    .clk(clk), .rst_n(rst_n), .en(loTc), .up(1'b1), .oneshot(1'b0), .load(1'b0),
    .load_val(4'd0), .count(hiCount), .tc(hiTc), .wrap(hiWrap), .done(hiDone), .load_err(hiErr));

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   nAssert = 0;
  int   nFail   = 0;

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    nAssert++;
    if (sb.size() == 0) begin
      nFail++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nFail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    aEn = 0; aUp = 1; aOne = 0; aLoad = 0; aLv = '0;
    bEn = 0; bUp = 1; bOne = 0; bLoad = 0; bLv = '0;
    cEn = 0;

    // Reset state
    tick();
    rst_n = 1'b1;
    push("rst_count", 0); check(8'(aCount));
    push("rst_wrap", 0);  check(8'(aWrap));
    push("rst_done", 0);  check(8'(aDone));
    push("rst_err", 0);   check(8'(aErr));

    // Count up with wrap, 14 edges
    aEn = 1; aUp = 1; aOne = 0;
    for (int i = 0; i < 14; i++) begin
      push("up_tc", 8'((i % 6) == 5)); check(8'(aTc));
      tick();
      push("up_count", 8'((i + 1) % 6)); check(8'(aCount));
      push("up_wrap", 8'((i % 6) == 5)); check(8'(aWrap));
    end

    // Count down from 2 through the 0->5 wrap
    aUp = 0;
    begin
      logic [7:0] dnCnt [4] = '{1, 0, 5, 4};
      logic [7:0] dnWrp [4] = '{0, 0, 1, 0};
      logic [7:0] dnTc  [4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
        push("dn_tc", dnTc[i]); check(8'(aTc));
        tick();
        push("dn_count", dnCnt[i]); check(8'(aCount));
        push("dn_wrap", dnWrp[i]);  check(8'(aWrap));
      end
    end

    // Illegal load on mod-6 holds count; then en=0 hold clears pulses
    aLoad = 1; aLv = 3'd7;
    tick();
    push("ill6_count", 4); check(8'(aCount));
    push("ill6_err", 1);   check(8'(aErr));
    aLoad = 0; aEn = 0;
    tick();
    push("hold_count", 4); check(8'(aCount));
    push("hold_err", 0);   check(8'(aErr));
    push("hold_tc", 0);    check(8'(aTc));

    // One-shot up from 3: 4,5,5,5 with done rising on the first hold
    aLoad = 1; aLv = 3'd3; aUp = 1;
    tick();
    push("os_load", 3); check(8'(aCount));
    aLoad = 0; aOne = 1; aEn = 1;
    begin
      logic [7:0] osCnt [4] = '{4, 5, 5, 5};
      logic [7:0] osDn  [4] = '{0, 0, 1, 1};
      for (int i = 0; i < 4; i++) begin
        tick();
        push("os_count", osCnt[i]); check(8'(aCount));
        push("os_done", osDn[i]);   check(8'(aDone));
        push("os_wrap", 0);         check(8'(aWrap));
      end
    end
    aLoad = 1; aLv = 3'd0;
    tick();
    push("os_clr_count", 0); check(8'(aCount));
    push("os_clr_done", 0);  check(8'(aDone));

    // Mod-10 loads: legal, illegal, boundary values, then wrap at 9
    bLoad = 1; bLv = 4'd7;
    tick();
    push("m10_ld7", 7);     check(8'(bCount));
    push("m10_ld7_err", 0); check(8'(bErr));
    bLv = 4'd12;
    tick();
    push("m10_ld12", 7);     check(8'(bCount));
    push("m10_ld12_err", 1); check(8'(bErr));
    bLv = 4'd9;
    tick();
    push("m10_ld9", 9);     check(8'(bCount));
    push("m10_ld9_err", 0); check(8'(bErr));
    bLv = 4'd10;
    tick();
    push("m10_ld10", 9);     check(8'(bCount));
    push("m10_ld10_err", 1); check(8'(bErr));
    bLoad = 0; bEn = 1;
    push("m10_tc", 1); check(8'(bTc));
    tick();
    push("m10_wrap_count", 0); check(8'(bCount));
    push("m10_wrap", 1);       check(8'(bWrap));
    push("m10_err_clr", 0);    check(8'(bErr));
    bEn = 0;

    // Cascade: 60 enabled clocks run the combined value 1..59 then back to 0
    cEn = 1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      push("cascade", 8'(k % 60));
      check(8'(hiCount) * 8'd6 + 8'(loCount));
    end
    cEn = 0;

    // Done set, direction change resumes counting, then reset beats load/en
    aOne = 1; aUp = 1; aEn = 0; aLoad = 1; aLv = 3'd5;
    tick();
    aLoad = 0; aEn = 1;
    tick();
    push("pre_done", 1); check(8'(aDone));
    aUp = 0;
    tick();
    push("resume_count", 4); check(8'(aCount));
    push("resume_done", 1);  check(8'(aDone));
    rst_n = 0; aLoad = 1; aLv = 3'd2; aEn = 1;
    tick();
    rst_n = 1; aLoad = 0; aEn = 0;
    push("mid_rst_count", 0); check(8'(aCount));
    push("mid_rst_wrap", 0);  check(8'(aWrap));
    push("mid_rst_done", 0);  check(8'(aDone));
    push("mid_rst_err", 0);   check(8'(aErr));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/modn_counter.md
Name: modn_counter

Overview:
- Parametrised modulo-N synchronous counter; the general-purpose successor to the fixed mod-6 D-flip-flop counter.
- Counts up or down over 0..MODULUS-1, supports synchronous load, enable, wrap or one-shot (saturating) mode, and provides a cascadable terminal-count output.
- Used as a sequence/timing generator and as a chainable stage for wider mixed-radix counters.

Parameters:
- MODULUS, 6, number of states; legal range 2..2^WIDTH.
- WIDTH, 3, count width in bits; 2^WIDTH >= MODULUS is required, checked at elaboration via $error.
- RESET_VAL, 0, count value after reset; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  count enable; doubles as carry-in when cascading.
- up  input  1  direction: 1 = increment, 0 = decrement.
- oneshot  input  1  mode: 1 = stop at terminal value, 0 = wrap.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  registered count.
- tc  output  1  combinational terminal count/carry-out.
- wrap  output  1  registered one-cycle pulse on wrap.
- done  output  1  registered sticky one-shot completion flag.
- load_err  output  1  registered one-cycle pulse on illegal load.

Behaviour:
- All state changes on the rising edge of clk. Reset is synchronous and active-low: rst_n is sampled only at the clk rising edge.
- Priority per edge: rst_n low > load > count > hold.
- Reset values:
  - count = RESET_VAL
  - wrap = 0
  - done = 0
  - load_err = 0
- Terminal value:
  - TERM = MODULUS-1 when up = 1.
  - TERM = 0 when up = 0.
- tc = en & (count == TERM). It is purely combinational, with zero latency, for cascade into the next stage's en.
- Load:
  - If load = 1 and load_val < MODULUS: count <= load_val, done <= 0, and wrap stays 0 that cycle.
  - If load = 1 and load_val >= MODULUS: count holds, load_err pulses 1 for one cycle, and done is unchanged.
  - load takes effect regardless of en.
- Count, when en = 1, load = 0 and count != TERM:
  - count <= count+1 if up = 1, else count-1.
  - No width overflow can occur.
- At terminal with en = 1, load = 0, oneshot = 0:
  - count <= 0 when counting up, MODULUS-1 when counting down.
  - wrap pulses 1 on the following cycle, i.e. registered alongside the new count.
- At terminal with en = 1, load = 0, oneshot = 1:
  - count holds at TERM, done <= 1, and wrap stays 0.
  - done stays 1 until reset or a legal load.
- Holding:
  - While done = 1 in oneshot mode, en has no effect on count unless up changes so that count != TERM, in which case counting resumes and done stays set.
  - en = 0: count holds, and wrap and load_err are 0.
- Direction change takes effect on the same edge with no pipeline; TERM follows up combinationally.
- Count out of range (count >= MODULUS) is unreachable by construction; the assertion (count < MODULUS) is required in simulation.
- Reset mid-operation overrides load and en in the same cycle. All pulses clear.

Test Plan:
- Reset, then en=1, up=1, oneshot=0, defaults, 14 clocks -> count 0,1,2,3,4,5,0,1,2,3,4,5,0,1. wrap is high the cycle after each 5->0. tc is high whenever count=5.
- up=0 from count=2, 4 clocks -> count 1,0,5,4. wrap pulses after 0->5. tc is high at count=0.
- MODULUS=10, WIDTH=4; load=1 with load_val=7, then load_val=12 -> count=7 then holds at 7. load_err pulses once on the second load.
- oneshot=1, up=1, count from 3 -> 4,5,5,5. done rises with the first hold at 5 and no wrap. A legal load of 0 clears done.
- Two instances cascaded (MODULUS 6 low, 10 high), high.en = low.tc -> high stage increments exactly once per 6 low-stage clocks. The combined value reaches 59 and then returns to 0 after 60 enabled clocks.
- rst_n low for 1 cycle while load=1 and en=1 at count=4 -> count=RESET_VAL next edge, all flags 0, and the load is ignored.
